mesi_isc_cbus_snoop_agent: RTL and testbench

Per-CPU coherence-bus endpoint, directly downstream of the MESI intersection controller's cbus outputs. It accepts one snoop/enable command at a time from `cbus_cmd_i`/`cbus_addr_i` and acknowledges it on `cbus_ack_o`. Accepted commands are buffered in a small FIFO and presented to the local cache controller over a valid/ready handshake. One instance sits on each of the four cbus ports.

---
 rtl/mesi_isc_snoop_pkg.sv | 16 +
 rtl/mesi_isc_cbus_snoop_agent_if.sv | 27 ++
 rtl/mesi_isc_basic_fifo.sv | 51 +++++
 rtl/mesi_isc_cbus_snoop_agent.sv | 90 +++++++++
 tb/tb_mesi_isc_cbus_snoop_agent.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mesi_isc_snoop_pkg.sv
// rtl/mesi_isc_snoop_pkg.sv - coherence-bus command codes and snoop agent FSM states
package mesi_isc_snoop_pkg;

  localparam int CBUS_CMD_NOP      = 0;
  localparam int CBUS_CMD_WR_SNOOP = 1;
  localparam int CBUS_CMD_RD_SNOOP = 2;
  localparam int CBUS_CMD_EN_WR    = 3;
  localparam int CBUS_CMD_EN_RD    = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_NOP = 2'd2
  } snoop_state_t;

endpackage

// File: rtl/mesi_isc_cbus_snoop_agent_if.sv
// rtl/mesi_isc_cbus_snoop_agent_if.sv - cbus command and cache snoop signals of one agent
interface mesi_isc_cbus_snoop_agent_if #(
  parameter int CBUS_CMD_WIDTH     = 3,
  parameter int ADDR_WIDTH         = 32,
  parameter int SNP_FIFO_SIZE_LOG2 = 2
);
  logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd_i;
  logic [ADDR_WIDTH-1:0]       cbus_addr_i;
  logic                        cbus_ack_o;
  logic                        snp_valid_o;
  logic [CBUS_CMD_WIDTH-1:0]   snp_cmd_o;
  logic [ADDR_WIDTH-1:0]       snp_addr_o;
  logic                        snp_ready_i;
  logic [SNP_FIFO_SIZE_LOG2:0] snp_count_o;
  logic                        snp_drop_o;

  // slave: the snoop agent; master: controller plus cache driving it
  modport slave (
    input  cbus_cmd_i, cbus_addr_i, snp_ready_i,
    output cbus_ack_o, snp_valid_o, snp_cmd_o, snp_addr_o, snp_count_o, snp_drop_o
  );

  modport master (
    output cbus_cmd_i, cbus_addr_i, snp_ready_i,
    input  cbus_ack_o, snp_valid_o, snp_cmd_o, snp_addr_o, snp_count_o, snp_drop_o
  );
endinterface

// File: rtl/mesi_isc_basic_fifo.sv
// rtl/mesi_isc_basic_fifo.sv - small show-ahead FIFO with same-cycle push/pop into a full buffer
module mesi_isc_basic_fifo #(
  parameter int DATA_WIDTH     = 35,
  parameter int FIFO_SIZE      = 4,
  parameter int FIFO_SIZE_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [FIFO_SIZE_LOG2:0]   count,
  output logic                      empty,
  output logic                      full
);

  logic [DATA_WIDTH-1:0]     mem [FIFO_SIZE];
  logic [FIFO_SIZE_LOG2-1:0] wr_ptr;
  logic [FIFO_SIZE_LOG2-1:0] rd_ptr;
  logic [FIFO_SIZE_LOG2:0]   count_q;
  logic                      do_push;
  logic                      do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (FIFO_SIZE_LOG2+1)'(FIFO_SIZE));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head reads as zero while empty so stale entries never leak after reset
  assign head_data = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/mesi_isc_cbus_snoop_agent.sv
// rtl/mesi_isc_cbus_snoop_agent.sv - per-CPU cbus endpoint: ack handshake FSM and snoop buffer
module mesi_isc_cbus_snoop_agent
  import mesi_isc_snoop_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH     = 3,
  parameter int ADDR_WIDTH         = 32,
  parameter int SNP_FIFO_SIZE      = 4,
  parameter int SNP_FIFO_SIZE_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  mesi_isc_cbus_snoop_agent_if.slave bus
);

  localparam int ENTRY_WIDTH = CBUS_CMD_WIDTH + ADDR_WIDTH;

  snoop_state_t               state;
  snoop_state_t               state_next;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       drop_set;
  logic                       drop_q;
  logic                       cmd_nop;
  logic                       cmd_legal;
  logic [ENTRY_WIDTH-1:0]     head_data;
  logic [SNP_FIFO_SIZE_LOG2:0] fifo_count;

  assign cmd_nop   = (bus.cbus_cmd_i == CBUS_CMD_WIDTH'(CBUS_CMD_NOP));
  assign cmd_legal = (bus.cbus_cmd_i <= CBUS_CMD_WIDTH'(CBUS_CMD_EN_RD));
  assign fifo_pop  = !fifo_empty && bus.snp_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_push  = 1'b0;
    drop_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cmd_nop) begin
          if (!cmd_legal) begin
            // Illegal codes are still acked so the controller cannot deadlock
            drop_set   = 1'b1;
            state_next = ST_ACK;
          end else if (!fifo_full || fifo_pop) begin
            fifo_push  = 1'b1;
            state_next = ST_ACK;
          end
        end
      end
      ST_ACK:      state_next = cmd_nop ? ST_IDLE : ST_WAIT_NOP;
      ST_WAIT_NOP: if (cmd_nop) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           drop_q <= 1'b0;
    else if (drop_set) drop_q <= 1'b1;
  end

  mesi_isc_basic_fifo #(
    .DATA_WIDTH     (ENTRY_WIDTH),
    .FIFO_SIZE      (SNP_FIFO_SIZE),
    .FIFO_SIZE_LOG2 (SNP_FIFO_SIZE_LOG2)
  ) u_snp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({bus.cbus_cmd_i, bus.cbus_addr_i}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.cbus_ack_o  = (state == ST_ACK);
  assign bus.snp_valid_o = !fifo_empty;
  assign bus.snp_cmd_o   = head_data[ENTRY_WIDTH-1:ADDR_WIDTH];
  assign bus.snp_addr_o  = head_data[ADDR_WIDTH-1:0];
  assign bus.snp_count_o = fifo_count;
  assign bus.snp_drop_o  = drop_q;

endmodule

// File: tb/tb_mesi_isc_cbus_snoop_agent.sv
// tb/tb_mesi_isc_cbus_snoop_agent.sv - scoreboard bench for the cbus snoop agent
module tb_mesi_isc_cbus_snoop_agent;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesi_isc_cbus_snoop_agent_if #(.CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .SNP_FIFO_SIZE_LOG2(2)) bus ();

  mesi_isc_cbus_snoop_agent #(
    .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .SNP_FIFO_SIZE(4), .SNP_FIFO_SIZE_LOG2(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int ack_count = 0;
  int lat;
  logic [34:0] exp_q [$];
  logic [34:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Pops happen on the next posedge when valid and ready are both high here
  always @(negedge clk) begin
    if (!rst && bus.cbus_ack_o) ack_count++;
    if (!rst && bus.snp_valid_o && bus.snp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_cmd",  64'(bus.snp_cmd_o),  64'(mon_e[34:32]));
        check("sb_addr", 64'(bus.snp_addr_o), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic send(input logic [2:0] cmd, input logic [31:0] addr, input int hold, output int latency);
    bus.cbus_cmd_i  = cmd;
    bus.cbus_addr_i = addr;
    if (cmd != 3'd0 && cmd <= 3'd4) exp_q.push_back({cmd, addr});
    latency = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.cbus_ack_o) begin
        latency = i;
        break;
      end
    end
    if (latency == 0) check("ack_timeout", 64'd0, 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("ack_held", 64'(bus.cbus_ack_o), 64'd0);
    end
    bus.cbus_cmd_i = 3'd0;
    @(posedge clk); #1;
    check("ack_single", 64'(bus.cbus_ack_o), 64'd0);
  endtask

  task automatic drain();
    bus.snp_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.snp_count_o == 3'd0) break;
    end
    bus.snp_ready_i = 1'b0;
    check("drain_count", 64'(bus.snp_count_o), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   64'(bus.cbus_ack_o),  64'd0);
    check({tag, "_valid"}, 64'(bus.snp_valid_o), 64'd0);
    check({tag, "_cmd"},   64'(bus.snp_cmd_o),   64'd0);
    check({tag, "_addr"},  64'(bus.snp_addr_o),  64'd0);
    check({tag, "_count"}, 64'(bus.snp_count_o), 64'd0);
    check({tag, "_drop"},  64'(bus.snp_drop_o),  64'd0);
  endtask

  initial begin
    int a0;
    int got;
    rst             = 1'b1;
    bus.cbus_cmd_i  = 3'd0;
    bus.cbus_addr_i = 32'd0;
    bus.snp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single snoop
    a0 = ack_count;
    send(3'd2, 32'h0000_1040, 0, lat);
    check("single_lat",   64'(lat), 64'd1);
    check("single_acks",  64'(ack_count - a0), 64'd1);
    check("single_valid", 64'(bus.snp_valid_o), 64'd1);
    check("single_cmd",   64'(bus.snp_cmd_o), 64'd2);
    check("single_addr",  64'(bus.snp_addr_o), 64'h1040);
    check("single_count", 64'(bus.snp_count_o), 64'd1);
    drain();

    // Held command is captured once; next command after NOP is accepted
    a0 = ack_count;
    send(3'd1, 32'h0000_2000, 3, lat);
    check("held_count", 64'(bus.snp_count_o), 64'd1);
    check("held_acks",  64'(ack_count - a0), 64'd1);
    send(3'd4, 32'h0000_2040, 0, lat);
    check("held_next_lat",   64'(lat), 64'd1);
    check("held_next_count", 64'(bus.snp_count_o), 64'd2);
    drain();

    // Fill to four back-to-back, then stall the fifth
    for (int k = 0; k < 4; k++) begin
      send(3'(k + 1), 32'h0000_3100 + 32'(k * 16), 0, lat);
      check("b2b_lat", 64'(lat), 64'd1);
    end
    check("full_count", 64'(bus.snp_count_o), 64'd4);
    bus.cbus_cmd_i  = 3'd3;
    bus.cbus_addr_i = 32'h0000_3000;
    exp_q.push_back({3'd3, 32'h0000_3000});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_ack",   64'(bus.cbus_ack_o), 64'd0);
      check("stall_count", 64'(bus.snp_count_o), 64'd4);
    end
    bus.snp_ready_i = 1'b1;
    got = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.snp_ready_i = 1'b0;
      if (bus.cbus_ack_o) begin
        got = 1;
        break;
      end
    end
    check("unstall_ack",   64'(got), 64'd1);
    check("unstall_count", 64'(bus.snp_count_o), 64'd4);
    bus.cbus_cmd_i = 3'd0;
    @(posedge clk); #1;
    drain();

    // Simultaneous push and pop at count two
    send(3'd1, 32'h0000_4010, 0, lat);
    send(3'd2, 32'h0000_4020, 0, lat);
    check("pp_pre_count", 64'(bus.snp_count_o), 64'd2);
    bus.cbus_cmd_i  = 3'd4;
    bus.cbus_addr_i = 32'h0000_4030;
    exp_q.push_back({3'd4, 32'h0000_4030});
    bus.snp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.snp_ready_i = 1'b0;
    check("pp_ack",       64'(bus.cbus_ack_o), 64'd1);
    check("pp_count",     64'(bus.snp_count_o), 64'd2);
    check("pp_head_cmd",  64'(bus.snp_cmd_o), 64'd2);
    check("pp_head_addr", 64'(bus.snp_addr_o), 64'h4020);
    bus.cbus_cmd_i = 3'd0;
    @(posedge clk); #1;
    drain();

    // Illegal code: acked, sticky drop, no push
    send(3'd6, 32'h0000_5000, 0, lat);
    check("illegal_lat",   64'(lat), 64'd1);
    check("illegal_drop",  64'(bus.snp_drop_o), 64'd1);
    check("illegal_count", 64'(bus.snp_count_o), 64'd0);
    send(3'd2, 32'h0000_5040, 0, lat);
    check("drop_sticky", 64'(bus.snp_drop_o), 64'd1);
    check("after_illegal_count", 64'(bus.snp_count_o), 64'd1);
    drain();

    // Reset with three buffered and the FSM in WAIT_NOP
    send(3'd1, 32'h0000_6000, 0, lat);
    send(3'd3, 32'h0000_6040, 0, lat);
    bus.cbus_cmd_i  = 3'd2;
    bus.cbus_addr_i = 32'h0000_6080;
    exp_q.push_back({3'd2, 32'h0000_6080});
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.cbus_ack_o) begin
        got = 1;
        break;
      end
    end
    check("rst_pre_ack", 64'(got), 64'd1);
    @(posedge clk); #1;
    check("rst_pre_count", 64'(bus.snp_count_o), 64'd3);
    check("rst_pre_drop",  64'(bus.snp_drop_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    bus.cbus_cmd_i = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(3'd4, 32'h0000_7000, 0, lat);
    check("post_rst_lat",   64'(lat), 64'd1);
    check("post_rst_count", 64'(bus.snp_count_o), 64'd1);
    drain();
    @(posedge clk); #1;
    check("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
